ysyx_23060332_wbu: RTL

//  Writeback unit: sole driver of the register-file write port (reg_wen/waddr/wdata).

---
 rtl/ysyx_23060332_wbu_pkg.sv | 34 +++
 rtl/ysyx_23060332_load_ext.sv | 44 ++++
 rtl/ysyx_23060332_wbu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ysyx_23060332_wbu_pkg.sv
// rtl/ysyx_23060332_wbu_pkg.sv - shared types and constants for the writeback unit
//
// Purpose : register-file bus widths, load funct3 encodings, WBU state
//           encoding and the latched load descriptor used by the top.
// Ports   : none (package).
package ysyx_23060332_wbu_pkg;

  localparam int XLEN = 32;  // RegDataBus width
  localparam int NREG = 32;  // architectural registers
  localparam int RA_W = 5;   // RegAddrBus width

  typedef logic [RA_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] reg_data_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    WBU_IDLE      = 1'b0,
    WBU_WAIT_LOAD = 1'b1
  } wbu_state_t;

  // Everything about an accepted load that is needed once the LSU word arrives.
  typedef struct packed {
    reg_addr_t  rd;
    logic       wen;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } load_info_t;

endpackage

// File: rtl/ysyx_23060332_load_ext.sv
// rtl/ysyx_23060332_load_ext.sv - load lane select and sign/zero extension
//
// Purpose : picks the byte/halfword lane of an aligned 32-bit word and
//           extends it to XLEN according to the load funct3.
// Ports   : word    in  32  aligned word from the LSU
//           funct3  in  3   load type (LB/LH/LW/LBU/LHU, others act as LW)
//           addr_lo in  2   load address bits [1:0]
//           data    out 32  extended load result
module ysyx_23060332_load_ext
  import ysyx_23060332_wbu_pkg::*;
(
  input  reg_data_t  word,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output reg_data_t  data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  // Halfword lane comes from addr_lo[1] only, so a misaligned LH silently
  // reads the lane it falls in; there is no fault path.
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = word;  // LW and undefined encodings
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_wbu.sv
// rtl/ysyx_23060332_wbu.sv - writeback unit with RAW scoreboard
//
// Purpose : sole driver of the register-file write port. Retires ALU results
//           from EXU directly and load results after the LSU word arrives,
//           and tracks pending destinations so IDU can stall on RAW hazards.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           issue_valid/issue_rd     reserve a destination in the scoreboard
//           q_addr1/2 -> q_busy1/2   combinational busy query for rs1/rs2
//           exu_valid/exu_ready      EXU result handshake
//           exu_rd/wen/wdata/load/funct3/addr_lo  EXU result fields
//           lsu_valid/lsu_ready      LSU load-word handshake, lsu_rdata word
//           reg_wen/waddr/wdata      registered regfile write port
//           wb_done                  one-cycle pulse per retired instruction
module ysyx_23060332_wbu
  import ysyx_23060332_wbu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  reg_addr_t  issue_rd,
  input  reg_addr_t  q_addr1,
  output logic       q_busy1,
  input  reg_addr_t  q_addr2,
  output logic       q_busy2,
  input  logic       exu_valid,
  output logic       exu_ready,
  input  reg_addr_t  exu_rd,
  input  logic       exu_wen,
  input  reg_data_t  exu_wdata,
  input  logic       exu_load,
  input  logic [2:0] exu_funct3,
  input  logic [1:0] exu_addr_lo,
  input  logic       lsu_valid,
  output logic       lsu_ready,
  input  reg_data_t  lsu_rdata,
  output logic       reg_wen,
  output reg_addr_t  waddr,
  output reg_data_t  wdata,
  output logic       wb_done
);

  wbu_state_t state_q, state_d;
  load_info_t ld_q, ld_d;

  logic      retire;
  reg_addr_t ret_rd;
  logic      ret_wen;
  reg_data_t ret_data;
  reg_data_t ld_data;

  logic [NREG-1:0] busy_q, busy_d;

  assign exu_ready = (state_q == WBU_IDLE);
  assign lsu_ready = (state_q == WBU_WAIT_LOAD);

  ysyx_23060332_load_ext u_load_ext (
    .word    (lsu_rdata),
    .funct3  (ld_q.funct3),
    .addr_lo (ld_q.addr_lo),
    .data    (ld_data)
  );

  // Next state plus the retiring instruction's write fields.
  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    retire   = 1'b0;
    ret_rd   = exu_rd;
    ret_wen  = exu_wen;
    ret_data = exu_wdata;
    case (state_q)
      WBU_IDLE: begin
        if (exu_valid) begin
          if (exu_load) begin
            ld_d.rd      = exu_rd;
            ld_d.wen     = exu_wen;
            ld_d.funct3  = exu_funct3;
            ld_d.addr_lo = exu_addr_lo;
            state_d      = WBU_WAIT_LOAD;
          end else begin
            retire = 1'b1;
          end
        end
      end
      WBU_WAIT_LOAD: begin
        ret_rd   = ld_q.rd;
        ret_wen  = ld_q.wen;
        ret_data = ld_data;
        if (lsu_valid) begin
          retire  = 1'b1;
          state_d = WBU_IDLE;
        end
      end
      default: state_d = WBU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WBU_IDLE;
      ld_q    <= '0;
      reg_wen <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      wb_done <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      reg_wen <= retire & ret_wen & (ret_rd != '0);
      wb_done <= retire;
      if (retire) begin
        waddr <= ret_rd;
        wdata <= ret_data;
      end
    end
  end

  // Clear comes from the registered write port so the busy bit drops on the
  // same edge the regfile takes the value; a reservation in that same cycle
  // is applied last and therefore wins. Bit 0 is forced low so x0 never stalls.
  always_comb begin
    busy_d = busy_q;
    if (reg_wen) busy_d[waddr] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign q_busy1 = busy_q[q_addr1];
  assign q_busy2 = busy_q[q_addr2];

endmodule
